// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: NS/EW traffic-light Moore FSM timed in ticks; optional ALL_RED_EN adds all-red clearance phases
module traffic_light_ctrl #(
  parameter int NS_GREEN_TICKS  = 5,
  parameter int NS_YELLOW_TICKS = 2,
  parameter int EW_GREEN_TICKS  = 5,
  parameter int EW_YELLOW_TICKS = 2,
  parameter int ALL_RED_TICKS   = 1,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  output logic       ns_g,
  output logic       ns_y,
  output logic       ns_r,
  output logic       ew_g,
  output logic       ew_y,
  output logic       ew_r,
  output logic [2:0] phase
);
  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    EW_G  = 3'd2,
    EW_Y  = 3'd3,
    AR_NS = 3'd4,
    AR_EW = 3'd5
  } state_t;
  localparam int MAXD = 1 << CNT_W;
  if (NS_GREEN_TICKS < 1 || NS_GREEN_TICKS >= MAXD || NS_YELLOW_TICKS < 1 || NS_YELLOW_TICKS >= MAXD ||
      EW_GREEN_TICKS < 1 || EW_GREEN_TICKS >= MAXD || EW_YELLOW_TICKS < 1 || EW_YELLOW_TICKS >= MAXD) begin : g_bad_dur
    $error("traffic_light_ctrl: phase duration must be in 1..2^CNT_W-1");
  end
`ifdef ALL_RED_EN
  if (ALL_RED_TICKS < 1 || ALL_RED_TICKS >= MAXD) begin : g_bad_ar
    $error("traffic_light_ctrl: ALL_RED_TICKS must be in 1..2^CNT_W-1");
  end
`endif
  state_t state, state_d, succ;
  logic [CNT_W-1:0] cnt, cnt_d, dur;
  logic legal, last;
  // state and phase counter register; reset restarts a full NS green
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NS_G;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end
  // phase duration, successor, and advance on the last tick of a phase
  always_comb begin
    dur = (state == NS_G) ? CNT_W'(NS_GREEN_TICKS) :
          (state == NS_Y) ? CNT_W'(NS_YELLOW_TICKS) :
          (state == EW_G) ? CNT_W'(EW_GREEN_TICKS) :
          (state == EW_Y) ? CNT_W'(EW_YELLOW_TICKS) : CNT_W'(ALL_RED_TICKS);
    last = cnt == dur - 1'b1;
`ifdef ALL_RED_EN
    legal = state <= AR_EW;
    succ = (state == NS_G)  ? NS_Y  :
           (state == NS_Y)  ? AR_NS :
           (state == AR_NS) ? EW_G  :
           (state == EW_G)  ? EW_Y  :
           (state == EW_Y)  ? AR_EW : NS_G;
`else
    legal = state <= EW_Y;
    succ = (state == NS_G) ? NS_Y :
           (state == NS_Y) ? EW_G :
           (state == EW_G) ? EW_Y : NS_G;
`endif
    state_d = !legal ? NS_G : (tick && last) ? succ : state;
    cnt_d = (!legal || (tick && last)) ? '0 : tick ? cnt + 1'b1 : cnt;
  end
  assign ns_g  = state == NS_G;
  assign ns_y  = state == NS_Y;
  assign ns_r  = !(ns_g || ns_y);
  assign ew_g  = state == EW_G;
  assign ew_y  = state == EW_Y;
  assign ew_r  = !(ew_g || ew_y);
  assign phase = state;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl: randomized self-checking bench against a tick-count schedule model
module tb_traffic_light_ctrl;
  localparam int NSG = 5, NSY = 2, EWG = 5, EWY = 2, ART = 1;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  logic [2:0] phase;
  int checks = 0, errors = 0;
  int tk = 0;
  int seqc[$], durs[$];
  int period = 0;
  always #5 clk = ~clk;
  traffic_light_ctrl #(
    .NS_GREEN_TICKS(NSG), .NS_YELLOW_TICKS(NSY), .EW_GREEN_TICKS(EWG),
    .EW_YELLOW_TICKS(EWY), .ALL_RED_TICKS(ART), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .ns_g(ns_g), .ns_y(ns_y), .ns_r(ns_r),
    .ew_g(ew_g), .ew_y(ew_y), .ew_r(ew_r),
    .phase(phase)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask
  function automatic int exp_phase(input int t);
    int m = t % period;
    for (int i = 0; i < seqc.size(); i++) begin
      if (m < durs[i]) return seqc[i];
      m -= durs[i];
    end
    return seqc[0];
  endfunction
  function automatic logic [2:0] ns_lamps(input int p);
    return (p == 0) ? 3'b100 : (p == 1) ? 3'b010 : 3'b001;
  endfunction
  function automatic logic [2:0] ew_lamps(input int p);
    return (p == 2) ? 3'b100 : (p == 3) ? 3'b010 : 3'b001;
  endfunction
  task automatic check_outputs();
    int p = exp_phase(tk);
    chk("phase", 32'(phase), p);
    chk("ns_lamps", 32'({ns_g, ns_y, ns_r}), 32'(ns_lamps(p)));
    chk("ew_lamps", 32'({ew_g, ew_y, ew_r}), 32'(ew_lamps(p)));
    chk("ns_onehot", 32'($onehot({ns_g, ns_y, ns_r})), 1);
    chk("ew_onehot", 32'($onehot({ew_g, ew_y, ew_r})), 1);
    chk("no_conflict", 32'((ns_g | ns_y) & (ew_g | ew_y)), 0);
  endtask
  task automatic step(input logic r, input logic t);
    rst = r;
    tick = t;
    @(posedge clk);
    tk = r ? 0 : tk + int'(t);
    @(negedge clk);
    check_outputs();
  endtask
  task automatic green_len(input string tag, input int every, input int exp);
    int n = 1;
    int i = 0;
    step(1'b1, 1'b0);
    while (i < 200) begin
      step(1'b0, (i % every) == every - 1);
      i++;
      if (phase != 3'd0) break;
      n++;
    end
    chk(tag, n, exp);
  endtask
  initial begin
    int target;
`ifdef ALL_RED_EN
    seqc = '{0, 1, 4, 2, 3, 5};
    durs = '{NSG, NSY, ART, EWG, EWY, ART};
`else
    seqc = '{0, 1, 2, 3};
    durs = '{NSG, NSY, EWG, EWY};
`endif
    foreach (durs[i]) period += durs[i];
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      chk("reset_phase", 32'(phase), 0);
      chk("reset_ns_g", 32'(ns_g), 1);
      chk("reset_ew_r", 32'(ew_r), 1);
    end
    for (int i = 0; i < 3 * period + 2; i++) step(1'b0, 1'b1);
    green_len("ns_g_len_tick1", 1, NSG);
    green_len("ns_g_len_tick4", 4, NSG * 4);
    for (int i = 0; i < 4 * period * 4; i++) step(1'b0, (i % 4) == 3);
    for (int i = 0; i < 400; i++) step($urandom_range(0, 49) == 0, 1'(($urandom_range(0, 1))));
    target = 1;
    foreach (seqc[i]) begin
      if (seqc[i] == 3) break;
      target += durs[i];
    end
    step(1'b1, 1'b0);
    for (int i = 0; i < 200 && tk % period != target; i++) step(1'b0, 1'b1);
    chk("reach_ew_y_cnt1", 32'(tk % period), target);
    chk("ew_y_before_rst", 32'(phase), 3);
    green_len("ns_g_len_after_rst", 1, NSG);
    for (int i = 0; i < 2 * period; i++) step(1'b0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
